// File: rtl/pwm_deadtime_pkg.sv
// Shared types and constants for the pwm_deadtime gate-pair block.
// Includes the reference saturation helper used when PWM_REF_CLAMP_EN is defined.
package pwm_pkg;

   localparam int unsigned NB_DATA       = 16;
   localparam int unsigned NB_DT         = 4;
   localparam int unsigned DT_CYCLES_DEF = 6;
   localparam logic [NB_DATA-1:0] REF_LIMIT = 16'h7800;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_DT_TO_HIGH,
      ST_HIGH_ON,
      ST_DT_TO_LOW,
      ST_LOW_ON,
      ST_FAULT
   } state_t;

   // Saturate a signed S(16,15) reference to [-lim, +lim].
   function automatic logic [NB_DATA-1:0] clamp_ref(input logic [NB_DATA-1:0] ref_in,
                                                    input logic [NB_DATA-1:0] lim);
      logic signed [NB_DATA-1:0] w_pos;
      logic signed [NB_DATA-1:0] w_neg;
      w_pos = $signed(lim);
      w_neg = -w_pos;
      if ($signed(ref_in) > w_pos)
         return w_pos;
      else if ($signed(ref_in) < w_neg)
         return w_neg;
      else
         return ref_in;
   endfunction

endpackage

// File: rtl/pwm_deadtime_fsm.sv
// Dead-time FSM: turns the raw comparator level into a complementary gate pair
// with a fixed off-gap on every transition and a latched fault shutdown.
module deadtime_fsm
   import pwm_pkg::*;
#(
   parameter int unsigned DT_CYCLES = DT_CYCLES_DEF,
   parameter int unsigned NB_DT     = pwm_pkg::NB_DT
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_raw,
   input  logic i_sync,
   input  logic i_fault,
   input  logic i_fault_clear,
   output logic o_gate_high,
   output logic o_gate_low,
   output logic o_fault
);

   localparam logic [NB_DT-1:0] DT_RELOAD = NB_DT'(DT_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [NB_DT-1:0] r_cnt;
   logic [NB_DT-1:0] w_cnt_next;
   logic             r_gate_high;
   logic             r_gate_low;
   logic             r_fault;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= ST_OFF;
         r_cnt       <= '0;
         r_gate_high <= 1'b0;
         r_gate_low  <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_gate_high <= (r_state == ST_HIGH_ON);
         r_gate_low  <= (r_state == ST_LOW_ON);
         r_fault     <= (r_state == ST_FAULT);
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      if (i_fault) begin
         w_state_next = ST_FAULT;
      end else begin
         unique case (r_state)
            ST_OFF: begin
               if (i_sync) begin
                  w_state_next = i_raw ? ST_DT_TO_HIGH : ST_DT_TO_LOW;
                  w_cnt_next   = DT_RELOAD;
               end
            end
            ST_DT_TO_HIGH: begin
               if (!i_raw) begin
                  w_state_next = ST_DT_TO_LOW;
                  w_cnt_next   = DT_RELOAD;
               end else if (r_cnt == '0) begin
                  w_state_next = ST_HIGH_ON;
               end else begin
                  w_cnt_next = r_cnt - 1'b1;
               end
            end
            ST_DT_TO_LOW: begin
               if (i_raw) begin
                  w_state_next = ST_DT_TO_HIGH;
                  w_cnt_next   = DT_RELOAD;
               end else if (r_cnt == '0) begin
                  w_state_next = ST_LOW_ON;
               end else begin
                  w_cnt_next = r_cnt - 1'b1;
               end
            end
            ST_HIGH_ON: begin
               if (!i_raw) begin
                  w_state_next = ST_DT_TO_LOW;
                  w_cnt_next   = DT_RELOAD;
               end
            end
            ST_LOW_ON: begin
               if (i_raw) begin
                  w_state_next = ST_DT_TO_HIGH;
                  w_cnt_next   = DT_RELOAD;
               end
            end
            ST_FAULT: begin
               if (i_fault_clear)
                  w_state_next = ST_OFF;
            end
            default: w_state_next = ST_OFF;
         endcase
      end
   end

   assign o_gate_high = r_gate_high;
   assign o_gate_low  = r_gate_low;
   assign o_fault     = r_fault;

endmodule

// File: rtl/pwm_deadtime.sv
// Half-bridge PWM leg: double-buffered reference, carrier comparator and dead-time FSM.
// Define PWM_REF_CLAMP_EN to saturate the reference to +/-REF_LIMIT at load time.
module pwm_deadtime
   import pwm_pkg::*;
#(
   parameter int unsigned NB_DATA   = pwm_pkg::NB_DATA,
   parameter int unsigned DT_CYCLES = DT_CYCLES_DEF,
   parameter int unsigned NB_DT     = pwm_pkg::NB_DT
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_carrier,
   input  logic               i_sync,
   input  logic [NB_DATA-1:0] i_reference,
   input  logic               i_ref_valid,
   input  logic               i_fault,
   input  logic               i_fault_clear,
   output logic               o_gate_high,
   output logic               o_gate_low,
   output logic               o_fault,
   output logic               o_ref_loaded
);

   logic [NB_DATA-1:0] r_pending;
   logic               r_pending_flag;
   logic [NB_DATA-1:0] r_active;
   logic               r_ref_loaded;
   logic [NB_DATA-1:0] w_ref_load;
   logic               w_load;
   logic               w_raw;

`ifdef PWM_REF_CLAMP_EN
   assign w_ref_load = clamp_ref(r_pending, REF_LIMIT);
`else
   assign w_ref_load = r_pending;
`endif

   // A write arriving with i_sync lands in pending only; the load uses the older pending value.
   assign w_load = i_sync && r_pending_flag;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_pending      <= '0;
         r_pending_flag <= 1'b0;
         r_active       <= '0;
         r_ref_loaded   <= 1'b0;
      end else begin
         r_ref_loaded <= w_load;
         if (w_load)
            r_active <= w_ref_load;
         if (i_ref_valid) begin
            r_pending      <= i_reference;
            r_pending_flag <= 1'b1;
         end else if (w_load) begin
            r_pending_flag <= 1'b0;
         end
      end
   end

   assign w_raw = ($signed(r_active) > $signed(i_carrier));

   deadtime_fsm #(
      .DT_CYCLES (DT_CYCLES),
      .NB_DT     (NB_DT)
   ) u_fsm (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_raw         (w_raw),
      .i_sync        (i_sync),
      .i_fault       (i_fault),
      .i_fault_clear (i_fault_clear),
      .o_gate_high   (o_gate_high),
      .o_gate_low    (o_gate_low),
      .o_fault       (o_fault)
   );

   assign o_ref_loaded = r_ref_loaded;

endmodule

// File: doc/pwm_deadtime.md
Name: pwm_deadtime

Overview:
- Consumes the S(16,15) triangular carrier from the carrier generator and the S(16,15) modulating reference from the control loop.
- Produces one complementary gate pair (high/low switch of a half-bridge leg) with dead-time insertion and a latched fault shutdown.
- Sits directly downstream of the carrier generator and drives the gate-driver pins.
- Runs on the 5.4 MHz system clock.

Parameters:
- NB_DATA, 16, width of carrier and reference, signed S(16,15).
- DT_CYCLES, 6, dead time in i_clock cycles (6 × 185 ns ≈ 1.11 µs); legal range 1..15.
- NB_DT, 4, dead-time counter width.
- REF_LIMIT, 16'h7800, clamp magnitude (0.9375); used only with REF_CLAMP_EN.

Ports:
- i_clock  in  1  system clock, 5.4 MHz
- i_reset  in  1  asynchronous, active-high reset
- i_carrier  in  NB_DATA  signed triangular carrier sample
- i_sync  in  1  single-cycle pulse at each carrier valley (period boundary)
- i_reference  in  NB_DATA  signed modulating reference
- i_ref_valid  in  1  qualifies i_reference for one cycle
- i_fault  in  1  external fault, level, already synchronous
- i_fault_clear  in  1  single-cycle fault acknowledge
- o_gate_high  out  1  high-side gate, active-high
- o_gate_low  out  1  low-side gate, active-high
- o_fault  out  1  latched fault status
- o_ref_loaded  out  1  single-cycle pulse when the active reference is updated

Behaviour:
- Reset: both gates 0, o_fault 0, o_ref_loaded 0. Pending and active reference 0, pending-flag 0. FSM in OFF, dead-time counter 0.
- Reference double buffering:
  - i_ref_valid writes i_reference into the pending register and sets pending-flag; a later write overwrites.
  - On i_sync with pending-flag set: pending → active, flag cleared, o_ref_loaded=1 the next cycle.
  - If i_ref_valid and i_sync occur in the same cycle, the new value goes to pending only; it is not loaded until the next i_sync.
- Comparator: raw = (active_ref > i_carrier), signed compare, combinational. Equality gives raw=0.
- FSM states: OFF, DT_TO_HIGH, HIGH_ON, DT_TO_LOW, LOW_ON, FAULT.
  - OFF: gates 0. On first i_sync with i_fault=0, go to DT_TO_HIGH if raw=1, else DT_TO_LOW. Load counter with DT_CYCLES-1.
  - DT_TO_x: gates 0, counter decrements. At 0, enter x_ON if raw still matches the target.
  - If raw flips during DT_TO_x, switch to the opposite DT state and reload the counter. Gates never both on and never on early.
  - HIGH_ON: o_gate_high=1. When raw=0, go to DT_TO_LOW with reload.
  - LOW_ON: o_gate_low=1. When raw=1, go to DT_TO_HIGH with reload.
- Gate outputs are registered and decoded from the state: one cycle of latency from a state change to the pins.
- Minimum off-time between complementary gates is exactly DT_CYCLES cycles.
- Fault handling:
  - i_fault=1 in any state → FAULT next cycle. Gates 0 and o_fault=1 on the following registered output.
  - FAULT exits to OFF only on i_fault_clear=1 with i_fault=0. Simultaneous fault and clear: fault wins, stay in FAULT.
  - OFF then restarts at the next i_sync.
- Gate invariant: o_gate_high & o_gate_low is never 1 in any state, including reset release.
- Reset mid-operation: gates go to 0 immediately (asynchronous), all state is lost, and a restart requires i_sync.

Optional Feature:
- Macro: PWM_REF_CLAMP_EN.
- Defined: the active reference is saturated to [-REF_LIMIT, +REF_LIMIT] at load time, so each switching period keeps a minimum pulse width.
- Undefined: the reference loads unmodified, and full-scale values can suppress pulses entirely.

Decomposition:
- Shared package pwm_pkg: NB_DATA, FSM state encoding constants, default DT_CYCLES, REF_LIMIT.
- One sub-module, deadtime_fsm: takes raw, i_sync and fault in, drives the gates out, and contains the counter and FSM.
- The top level holds the reference double-buffer, the clamp and the comparator.

Test Plan:
- Reference 16'h0000 with the triangle carrier: about 50% duty per leg, both gates low for exactly 6 cycles at every edge, never both high.
- i_ref_valid with 16'h4000 mid-period: duty unchanged until the next i_sync, then o_ref_loaded pulses once and high-side duty rises to about 75%.
- raw toggles 1→0→1 within 3 cycles during DT_TO_HIGH: counter reloads twice, gates stay 0, high-side turns on 6 cycles after the last toggle.
- i_fault asserted while HIGH_ON: gates 0 within 2 cycles and o_fault=1; fault plus clear together stays FAULT; clear with i_fault=0 gives OFF, and the next i_sync restarts.
- With PWM_REF_CLAMP_EN, reference 16'h7FFF: active value 16'h7800 and the low-side still pulses each period. Without the macro, the low-side stays off for the full period.
- i_reset asserted while LOW_ON: o_gate_low=0 asynchronously; after release, gates stay 0 until the first i_sync.
